// File: rtl/mac_pkg.sv
// Shared types and helpers for the pipelined multiply-accumulate engine.
package mac_pkg;

  // Widest channel index the engine supports (16 channels).
  localparam int unsigned CH_W_MAX  = 4;
  // Widest accumulator the range helpers can describe.
  localparam int unsigned ACC_W_MAX = 128;

  typedef logic [ACC_W_MAX-1:0] acc_wide_t;

  // Control record that travels alongside each product through the pipeline.
  typedef struct packed {
    logic                valid;
    logic [CH_W_MAX-1:0] ch;
    logic                acc_mode;
  } stage_t;

  // Width of the channel index port; never narrower than one bit.
  function automatic int unsigned ch_width(input int unsigned channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // Largest value representable in an accumulator of the given width.
  function automatic acc_wide_t acc_max(input int unsigned width, input bit is_signed);
    acc_wide_t v;
    v = '0;
    for (int unsigned i = 0; i < width; i++) begin
      v[i] = 1'b1;
    end
    if (is_signed) begin
      v[width-1] = 1'b0;
    end
    return v;
  endfunction

  // Smallest value representable in an accumulator of the given width.
  function automatic acc_wide_t acc_min(input int unsigned width, input bit is_signed);
    acc_wide_t v;
    v = '0;
    if (is_signed) begin
      v[width-1] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/mac_mult_pipe.sv
// Operand extension, multiply and a PIPE_STAGES-deep valid/data shift.
// The first stage registers the raw operands; the product is formed from
// those registers and then delayed by the remaining PIPE_STAGES-1 stages.
module mac_mult_pipe
  import mac_pkg::*;
#(
  parameter int unsigned ASIZE       = 16,
  parameter int unsigned BSIZE       = 16,
  parameter bit          A_SIGNED    = 1'b1,
  parameter bit          B_SIGNED    = 1'b1,
  parameter int unsigned PIPE_STAGES = 3,
  parameter int unsigned CH_W        = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ce,
  input  logic                   in_valid,
  input  logic [CH_W-1:0]        in_ch,
  input  logic                   in_acc,
  input  logic [ASIZE-1:0]       a,
  input  logic [BSIZE-1:0]       b,
  output stage_t                 p_meta,
  output logic [ASIZE+BSIZE-1:0] p
);

  localparam int unsigned PW = ASIZE + BSIZE;

  logic [ASIZE-1:0]     a_q;
  logic [BSIZE-1:0]     b_q;
  stage_t               s1_q;
  logic signed [ASIZE:0] a_ext;
  logic signed [BSIZE:0] b_ext;
  logic [PW-1:0]        prod;

  // Stage 1: capture operands and their control record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      s1_q <= '0;
    end else if (ce) begin
      a_q  <= a;
      b_q  <= b;
      s1_q <= '{valid: in_valid, ch: CH_W_MAX'(in_ch), acc_mode: in_acc};
    end
  end

  // One extra bit per operand lets a single signed multiply cover every
  // signed/unsigned combination; the low PW bits are the exact product.
  always_comb begin
    a_ext = {(A_SIGNED ? a_q[ASIZE-1] : 1'b0), a_q};
    b_ext = {(B_SIGNED ? b_q[BSIZE-1] : 1'b0), b_q};
    prod  = PW'((PW + 2)'(a_ext) * (PW + 2)'(b_ext));
  end

  generate
    if (PIPE_STAGES == 1) begin : g_direct
      assign p      = prod;
      assign p_meta = s1_q;
    end else begin : g_shift
      logic [PW-1:0] prod_q [PIPE_STAGES-1];
      stage_t        meta_q [PIPE_STAGES-1];

      // Remaining stages: product and control shift together, bubbles included.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < PIPE_STAGES - 1; i++) begin
            prod_q[i] <= '0;
            meta_q[i] <= '0;
          end
        end else if (ce) begin
          prod_q[0] <= prod;
          meta_q[0] <= s1_q;
          for (int unsigned i = 1; i < PIPE_STAGES - 1; i++) begin
            prod_q[i] <= prod_q[i-1];
            meta_q[i] <= meta_q[i-1];
          end
        end
      end

      assign p      = prod_q[PIPE_STAGES-2];
      assign p_meta = meta_q[PIPE_STAGES-2];
    end
  endgenerate

endmodule

// File: rtl/mac_pipe.sv
// Pipelined multiply-accumulate engine: product pipeline feeding a bank of
// per-channel accumulators with optional saturation and sticky overflow.
module mac_pipe
  import mac_pkg::*;
#(
  parameter int unsigned ASIZE       = 16,
  parameter int unsigned BSIZE       = 16,
  parameter bit          A_SIGNED    = 1'b1,
  parameter bit          B_SIGNED    = 1'b1,
  parameter int unsigned PIPE_STAGES = 3,
  parameter int unsigned ACC_SIZE    = 40,
  parameter int unsigned CHANNELS    = 2,
  parameter bit          SAT_EN      = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              ce,
  input  logic                              in_valid,
  input  logic [ch_width(CHANNELS)-1:0]     in_ch,
  input  logic                              in_acc,
  input  logic [ASIZE-1:0]                  a,
  input  logic [BSIZE-1:0]                  b,
  output logic                              p_valid,
  output logic [ch_width(CHANNELS)-1:0]     p_ch,
  output logic [ASIZE+BSIZE-1:0]            p,
  output logic                              acc_valid,
  output logic [ch_width(CHANNELS)-1:0]     acc_ch,
  output logic [ACC_SIZE-1:0]               acc,
  output logic                              acc_ovf
);

  localparam int unsigned          CH_W        = ch_width(CHANNELS);
  localparam int unsigned          PW          = ASIZE + BSIZE;
  localparam bit                   SIGNED_MODE = A_SIGNED || B_SIGNED;
  localparam logic [ACC_SIZE-1:0]  ACC_MAX     = ACC_SIZE'(acc_max(ACC_SIZE, SIGNED_MODE));
  localparam logic [ACC_SIZE-1:0]  ACC_MIN     = ACC_SIZE'(acc_min(ACC_SIZE, SIGNED_MODE));

  stage_t              p_meta;
  logic [ACC_SIZE-1:0] acc_q [CHANNELS];
  logic [CHANNELS-1:0] ovf_q;

  logic [CH_W-1:0]     ch_idx;
  logic                ch_ok;
  logic [ACC_SIZE-1:0] cur;
  logic [ACC_SIZE:0]   p_ext;
  logic [ACC_SIZE:0]   cur_ext;
  logic [ACC_SIZE:0]   sum;
  logic                sum_ovf;
  logic [ACC_SIZE-1:0] acc_d;
  logic                ovf_d;

  mac_mult_pipe #(
    .ASIZE       (ASIZE),
    .BSIZE       (BSIZE),
    .A_SIGNED    (A_SIGNED),
    .B_SIGNED    (B_SIGNED),
    .PIPE_STAGES (PIPE_STAGES),
    .CH_W        (CH_W)
  ) u_mult (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .in_valid (in_valid),
    .in_ch    (in_ch),
    .in_acc   (in_acc),
    .a        (a),
    .b        (b),
    .p_meta   (p_meta),
    .p        (p)
  );

  assign p_valid = p_meta.valid;
  assign p_ch    = ch_idx;

  // Next accumulator value: one extra bit exposes overflow, then clamp or wrap.
  always_comb begin
    ch_idx  = p_meta.ch[CH_W-1:0];
    ch_ok   = p_meta.valid && (32'(p_meta.ch) < CHANNELS);
    cur     = acc_q[ch_idx];
    p_ext   = {{(ACC_SIZE + 1 - PW){(SIGNED_MODE ? p[PW-1] : 1'b0)}}, p};
    cur_ext = {(SIGNED_MODE ? cur[ACC_SIZE-1] : 1'b0), cur};
    sum     = p_meta.acc_mode ? (cur_ext + p_ext) : p_ext;
    sum_ovf = SIGNED_MODE ? (sum[ACC_SIZE] != sum[ACC_SIZE-1]) : sum[ACC_SIZE];
    if (sum_ovf && SAT_EN) begin
      acc_d = (SIGNED_MODE && sum[ACC_SIZE]) ? ACC_MIN : ACC_MAX;
    end else begin
      acc_d = sum[ACC_SIZE-1:0];
    end
    ovf_d = p_meta.acc_mode ? (ovf_q[ch_idx] | sum_ovf) : 1'b0;
  end

  // Accumulator bank: only valid beats on an existing channel write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        acc_q[i] <= '0;
      end
      ovf_q <= '0;
    end else if (ce && ch_ok) begin
      acc_q[ch_idx] <= acc_d;
      ovf_q[ch_idx] <= ovf_d;
    end
  end

  // Output register: mirrors the value just written into the bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_valid <= 1'b0;
      acc_ch    <= '0;
      acc       <= '0;
      acc_ovf   <= 1'b0;
    end else if (ce) begin
      acc_valid <= ch_ok;
      if (ch_ok) begin
        acc_ch  <= ch_idx;
        acc     <= acc_d;
        acc_ovf <= ovf_d;
      end
    end
  end

endmodule
